// File: rtl/apb_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_memory_pkg
// Description : Shared types and default sizing for the APB scratch memory.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_memory_pkg;

  // Default geometry: 64 words of 32 bits behind a 6-bit word address
  localparam int unsigned c_addr_width = 6;
  localparam int unsigned c_data_width = 32;
  localparam int unsigned c_mem_depth  = 64;

  // Phase seen on the bus in the previous cycle
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } phase_t;

  // True when a word address selects an implemented location
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage : apb_memory_pkg
`default_nettype wire

// File: rtl/apb_memory_array.sv
`default_nettype none
// ============================================================================
// Module      : apb_memory_array
// Description : Word-organised register file with asynchronous clear, one
//               synchronous write port, a combinational read port and an
//               address-in-range flag. Out-of-range reads return zero and
//               out-of-range writes are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_memory_array
  import apb_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = c_addr_width,
  parameter int unsigned DATA_WIDTH = c_data_width,
  parameter int unsigned MEM_DEPTH  = c_mem_depth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_in_range
);

  // Word index width; the address is assumed at least this wide
  localparam int unsigned c_idx_w = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic                  w_in_range;
  logic [c_idx_w-1:0]    w_idx;
  logic [DATA_WIDTH-1:0] w_words [MEM_DEPTH];

  assign w_in_range = addr_in_range(32'(i_addr), MEM_DEPTH);
  assign w_idx      = i_addr[c_idx_w-1:0];

  // One register per word so each location has its own clear and enable
  for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
    logic [DATA_WIDTH-1:0] r_word;
    logic                  w_sel;

    assign w_sel = i_we && w_in_range && (w_idx == c_idx_w'(gi));

    // Word storage: cleared by reset, loaded when this word is written
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word <= '0;
      end else if (w_sel) begin
        r_word <= i_wdata;
      end
    end

    assign w_words[gi] = r_word;
  end

  assign o_rdata    = w_in_range ? w_words[w_idx] : '0;
  assign o_in_range = w_in_range;

endmodule : apb_memory_array
`default_nettype wire

// File: rtl/apb_memory.sv
`default_nettype none
// ============================================================================
// Module      : apb_memory
// Description : Zero-wait-state APB slave fronting a register-file memory.
//               Tracks the previous bus phase, flags protocol violations
//               and out-of-range addresses through Pslverr, commits writes
//               at the end of a valid access and captures read data at the
//               end of the read setup cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_memory
  import apb_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = c_addr_width,
  parameter int unsigned DATA_WIDTH = c_data_width,
  parameter int unsigned MEM_DEPTH  = c_mem_depth
) (
  input  logic                  Pclk,
  input  logic                  Prst,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic                  Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [DATA_WIDTH-1:0] Pwdata,
  output logic                  Pready,
  output logic                  Pslverr,
  output logic [DATA_WIDTH-1:0] Prdata
);

  phase_t                r_ph;
  phase_t                w_ph_nxt;
  logic                  w_access_ok;
  logic                  w_proto_err;
  logic                  w_pready;
  logic                  w_pslverr;
  logic                  w_we;
  logic                  w_rd_setup;
  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] r_prdata;

  // Phase register: remembers what the bus did in the previous cycle
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      r_ph <= PH_IDLE;
    end else begin
      r_ph <= w_ph_nxt;
    end
  end

  // Next phase follows the current select/enable pair directly
  always_comb begin
    w_ph_nxt = PH_IDLE;
    if (Pselx && !Penable) begin
      w_ph_nxt = PH_SETUP;
    end else if (Pselx && Penable) begin
      w_ph_nxt = PH_ACCESS;
    end
  end

  // Response decode; outputs are held low while reset is asserted so an
  // aborted transfer never reports completion
  always_comb begin
    w_access_ok = 1'b0;
    w_proto_err = 1'b0;
    w_pready    = 1'b0;
    w_pslverr   = 1'b0;
    w_we        = 1'b0;
    w_rd_setup  = 1'b0;
    if (Prst && Pselx && Penable) begin
      w_access_ok = (r_ph == PH_SETUP);
      w_proto_err = (r_ph != PH_SETUP);
      w_pready    = 1'b1;
      w_pslverr   = w_proto_err || !w_in_range;
      w_we        = w_access_ok && Pwrite && !w_pslverr;
    end
    if (Pselx && !Penable && !Pwrite) begin
      w_rd_setup = 1'b1;
    end
  end

  // Read data captured at the end of a read setup; held until the next one
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      r_prdata <= '0;
    end else if (w_rd_setup) begin
      r_prdata <= w_rdata;
    end
  end

  apb_memory_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk        (Pclk),
    .rst_n      (Prst),
    .i_we       (w_we),
    .i_addr     (Paddr),
    .i_wdata    (Pwdata),
    .o_rdata    (w_rdata),
    .o_in_range (w_in_range)
  );

  assign Pready  = w_pready;
  assign Pslverr = w_pslverr;
  assign Prdata  = r_prdata;

endmodule : apb_memory
`default_nettype wire

// File: tb/tb_apb_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_memory
// Description : Self-checking bench for apb_memory: directed scenarios with
//               literal expectations plus randomized bus traffic compared
//               every cycle against a behavioural memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_memory;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic          Pclk;
  logic          Prst;
  logic [AW-1:0] Paddr;
  logic          Pselx;
  logic          Penable;
  logic          Pwrite;
  logic [DW-1:0] Pwdata;
  logic          Pready;
  logic          Pslverr;
  logic [DW-1:0] Prdata;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain word array, last read result, and whether the
  // previous cycle was a setup cycle
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_prdata;
  bit            m_prev_setup;

  apb_memory dut (
    .Pclk    (Pclk),
    .Prst    (Prst),
    .Paddr   (Paddr),
    .Pselx   (Pselx),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Pwdata  (Pwdata),
    .Pready  (Pready),
    .Pslverr (Pslverr),
    .Prdata  (Prdata)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  task automatic check_word(input string name, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_prdata     = '0;
    m_prev_setup = 1'b0;
  endtask

  // Model state update at each rising edge
  always @(posedge Pclk) begin
    if (Prst !== 1'b1) begin
      model_clear();
    end else begin
      if (Pselx === 1'b1 && Penable === 1'b1 && m_prev_setup &&
          Pwrite === 1'b1 && int'(Paddr) < DEPTH)
        m_mem[Paddr] = Pwdata;
      if (Pselx === 1'b1 && Penable === 1'b0 && Pwrite === 1'b0)
        m_prdata = (int'(Paddr) < DEPTH) ? m_mem[Paddr] : '0;
      m_prev_setup = (Pselx === 1'b1 && Penable === 1'b0);
    end
  end

  always @(negedge Prst) model_clear();

  // Per-cycle comparison on the falling edge
  always @(negedge Pclk) begin
    logic e_rdy;
    logic e_err;
    if (Prst !== 1'b1) begin
      check_bit("cyc_pready_rst", Pready, 1'b0);
      check_bit("cyc_pslverr_rst", Pslverr, 1'b0);
      check_word("cyc_prdata_rst", Prdata, '0);
    end else begin
      e_rdy = (Pselx === 1'b1 && Penable === 1'b1);
      e_err = e_rdy && (!m_prev_setup || int'(Paddr) >= DEPTH);
      check_bit("cyc_pready", Pready, e_rdy);
      check_bit("cyc_pslverr", Pslverr, e_err);
      check_word("cyc_prdata", Prdata, m_prdata);
    end
  end

  task automatic idle_cycle();
    Pselx   = 1'b0;
    Penable = 1'b0;
    Pwrite  = 1'($urandom_range(0, 1));
    Paddr   = AW'($urandom);
    Pwdata  = $urandom;
    @(posedge Pclk); #1;
  endtask

  task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    Pselx = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = a; Pwdata = d;
    @(posedge Pclk); #1;
    Penable = 1'b1;
    #3;
    check_bit("wr_pready", Pready, 1'b1);
    check_bit("wr_pslverr", Pslverr, 1'b0);
    @(posedge Pclk); #1;
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    Pselx = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = a;
    @(posedge Pclk); #1;
    Penable = 1'b1;
    #3;
    check_bit("rd_pready", Pready, 1'b1);
    check_bit("rd_pslverr", Pslverr, 1'b0);
    d = Prdata;
    @(posedge Pclk); #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    Pselx = 1'b0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    Prst  = 1'b1;

    // Reset pulse of 5 ns with an enable strobe present to test output gating
    #1 Prst = 1'b0; Pselx = 1'b1; Penable = 1'b1;
    #1;
    check_bit("rst_pready", Pready, 1'b0);
    check_bit("rst_pslverr", Pslverr, 1'b0);
    check_word("rst_prdata", Prdata, 32'h0);
    #4 Prst = 1'b1; Pselx = 1'b0; Penable = 1'b0;
    @(posedge Pclk); #1;
    apb_read(6'd10, d);
    check_word("rst_read10", d, 32'h0);

    // Write then read back with select held high
    apb_write(6'h24, 32'h12153524);
    apb_read(6'h24, d);
    check_word("rb_24", d, 32'h12153524);
    idle_cycle();
    check_word("rb_24_hold", Prdata, 32'h12153524);

    // Two pairs, including the top word
    apb_write(6'h01, 32'hC0895E81);
    apb_read(6'h01, d);
    check_word("rb_01", d, 32'hC0895E81);
    apb_write(6'h3F, 32'h8484D609);
    apb_read(6'h3F, d);
    check_word("rb_3f", d, 32'h8484D609);
    apb_read(6'h01, d);
    check_word("rb_01_again", d, 32'hC0895E81);
    idle_cycle();

    // Enable without setup: error response and no write
    Pselx = 1'b1; Penable = 1'b1; Pwrite = 1'b1; Paddr = 6'd5; Pwdata = 32'hDEADBEEF;
    #3;
    check_bit("perr_pready", Pready, 1'b1);
    check_bit("perr_pslverr", Pslverr, 1'b1);
    @(posedge Pclk); #1;
    idle_cycle();
    apb_read(6'd5, d);
    check_word("perr_mem5", d, 32'h0);
    idle_cycle();

    // Enable held a second cycle after a valid write
    apb_write(6'd9, 32'hA5A50009);
    Pwdata = 32'h5A5AFFFF;
    #3;
    check_bit("ext_pready", Pready, 1'b1);
    check_bit("ext_pslverr", Pslverr, 1'b1);
    @(posedge Pclk); #1;
    idle_cycle();
    apb_read(6'd9, d);
    check_word("ext_mem9", d, 32'hA5A50009);

    // Reset during the access phase of a write
    Pselx = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 6'd7; Pwdata = 32'h77777777;
    @(posedge Pclk); #1;
    Penable = 1'b1;
    #2 Prst = 1'b0;
    #1;
    check_bit("mrst_pready", Pready, 1'b0);
    check_bit("mrst_pslverr", Pslverr, 1'b0);
    check_word("mrst_prdata", Prdata, 32'h0);
    @(posedge Pclk); #1;
    Prst = 1'b1; Pselx = 1'b0; Penable = 1'b0;
    @(posedge Pclk); #1;
    apb_read(6'd7, d);
    check_word("mrst_mem7", d, 32'h0);
    apb_read(6'd9, d);
    check_word("mrst_mem9", d, 32'h0);
    idle_cycle();

    // Randomized traffic; the per-cycle compare does the checking
    for (int n = 0; n < 600; n++) begin
      Pselx   = ($urandom_range(0, 4) != 0);
      Penable = 1'($urandom_range(0, 1));
      Pwrite  = 1'($urandom_range(0, 1));
      Paddr   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      Pwdata  = $urandom;
      @(posedge Pclk); #1;
    end
    idle_cycle();
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_apb_memory
`default_nettype wire
